// File: rtl/cpu_insn_fifo_if.sv
// Fetch/decode handshake bundle for cpu_insn_fifo.
// slave is the FIFO side; master drives fetch writes and decode reads.
interface cpu_insn_fifo_if;
    logic        write_i;
    logic [31:0] data_i;
    logic        full_o;
    logic [15:0] opcode_o;
    logic [31:0] operand_o;
    logic        valid_o;
    logic        read_i;

    modport master (
        output write_i, data_i, read_i,
        input  full_o, opcode_o, operand_o, valid_o
    );

    modport slave (
        input  write_i, data_i, read_i,
        output full_o, opcode_o, operand_o, valid_o
    );
endinterface

// File: rtl/cpu_insn_fifo.sv
// Instruction FIFO: 32-bit fetch words in, whole 16/48-bit instructions out.
// Optional flush_i port and logic enabled by defining CPU_IFIFO_FLUSH_EN.
module cpu_insn_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
`ifdef CPU_IFIFO_FLUSH_EN
    input  logic           flush_i,
`endif
    cpu_insn_fifo_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [AW-1:0] head1;
    logic [AW-1:0] head2;
    logic [AW-1:0] pop_step;
    logic          head_long;
    logic          full;
    logic          valid;
    logic          do_write;
    logic          do_pop;

    assign head1 = head + AW'(1);
    assign head2 = head + AW'(2);

    always_comb begin
        head_long = 1'b0;
        case (mem[head][15:8])
            8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
            8'h1F, 8'h20, 8'h22, 8'h24, 8'h30, 8'h36, 8'h37, 8'h38, 8'h39:
                head_long = 1'b1;
            default:
                head_long = 1'b0;
        endcase
    end

    assign full     = (count > CW'(DEPTH - 2));
    assign valid    = head_long ? (count >= CW'(3)) : (count >= CW'(1));
    assign pop_step = head_long ? AW'(3) : AW'(1);
    assign do_pop   = valid & bus.read_i;
`ifdef CPU_IFIFO_FLUSH_EN
    assign do_write = bus.write_i & ~full & ~flush_i;
`else
    assign do_write = bus.write_i & ~full;
`endif

    always_comb begin
        count_nxt = count;
        if (do_write) count_nxt = count_nxt + CW'(2);
        if (do_pop)   count_nxt = count_nxt - (head_long ? CW'(3) : CW'(1));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end
`ifdef CPU_IFIFO_FLUSH_EN
        else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end
`endif
        else begin
            if (do_write) tail <= tail + AW'(2);
            if (do_pop)   head <= head + pop_step;
            count <= count_nxt;
        end
    end

    // Storage is deliberately left out of reset; only the pointers matter.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem[tail]          <= bus.data_i[31:16];
            mem[tail + AW'(1)] <= bus.data_i[15:0];
        end
    end

    assign bus.opcode_o  = mem[head];
    assign bus.operand_o = {mem[head1], mem[head2]};
    assign bus.valid_o   = valid;
    assign bus.full_o    = full;
endmodule

// File: tb/tb_cpu_insn_fifo.sv
// Self-checking bench for cpu_insn_fifo: halfword scoreboard monitor plus directed scenarios.
// The flush scenario is compiled in when CPU_IFIFO_FLUSH_EN is defined.
module tb_cpu_insn_fifo;
    localparam int unsigned DEPTH = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
`ifdef CPU_IFIFO_FLUSH_EN
    logic flush_i = 1'b0;
`endif

    cpu_insn_fifo_if bus ();

    cpu_insn_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
`ifdef CPU_IFIFO_FLUSH_EN
        .flush_i (flush_i),
`endif
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int overflow = 0;
    int pops     = 0;

    logic [15:0] mq [$];
    logic [7:0]  long_ops [18] = '{8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D,
                                   8'h1A, 8'h1B, 8'h1D, 8'h1F, 8'h20, 8'h22,
                                   8'h24, 8'h30, 8'h36, 8'h37, 8'h38, 8'h39};

    function automatic bit op_long(input logic [15:0] op);
        for (int i = 0; i < 18; i++)
            if (op[15:8] == long_ops[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_valid();
        if (mq.size() == 0) return 1'b0;
        if (op_long(mq[0])) return (mq.size() >= 3);
        return 1'b1;
    endfunction

    function automatic logic [15:0] gen_hw();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) h[15:8] = long_ops[$urandom_range(0, 17)];
        return h;
    endfunction

    // Scoreboard: halfwords pushed on accepted writes, popped on decode reads.
    always @(negedge clk_i) begin : monitor
        bit ev;
        bit ef;
        bit lg;
        if (!rst_i) begin
            mq.delete();
        end else begin
            ev = model_valid();
            ef = (mq.size() > int'(DEPTH - 2));
            lg = 1'b0;
            if (mq.size() > 0) lg = op_long(mq[0]);
            checks++;
            if (bus.valid_o !== ev) begin
                failures++;
                $display("FAIL mon_valid t=%0t got=%b exp=%b", $time, bus.valid_o, ev);
            end
            checks++;
            if (bus.full_o !== ef) begin
                failures++;
                $display("FAIL mon_full t=%0t got=%b exp=%b", $time, bus.full_o, ef);
            end
            if (ev) begin
                checks++;
                if (bus.opcode_o !== mq[0]) begin
                    failures++;
                    $display("FAIL mon_opcode t=%0t got=%h exp=%h", $time, bus.opcode_o, mq[0]);
                end
                if (lg) begin
                    checks++;
                    if (bus.operand_o !== {mq[1], mq[2]}) begin
                        failures++;
                        $display("FAIL mon_operand t=%0t got=%h exp=%h", $time, bus.operand_o, {mq[1], mq[2]});
                    end
                end
            end
`ifdef CPU_IFIFO_FLUSH_EN
            if (flush_i) begin
                mq.delete();
            end else
`endif
            begin
                if (bus.read_i && ev) begin
                    pops++;
                    repeat (lg ? 3 : 1) void'(mq.pop_front());
                end
                if (bus.write_i) begin
                    if (ef) begin
                        overflow++;
                        $display("note: write while full at t=%0t, word dropped", $time);
                    end else begin
                        mq.push_back(bus.data_i[31:16]);
                        mq.push_back(bus.data_i[15:0]);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.full_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state valid=%b full=%b exp=0/0", bus.valid_o, bus.full_o);
        end
        rst_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            checks++;
            if (bus.valid_o !== 1'b0 || bus.full_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d valid=%b full=%b exp=0/0", i, bus.valid_o, bus.full_o);
            end
            cyc();
        end
    endtask

    task automatic test_short_pair();
        bus.write_i = 1'b1;
        bus.data_i  = 32'h8105_0000;
        bus.read_i  = 1'b1;
        cyc();
        bus.write_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.opcode_o !== 16'h8105) begin
            failures++;
            $display("FAIL short_first valid=%b op=%h exp=1/8105", bus.valid_o, bus.opcode_o);
        end
        cyc();
        @(negedge clk_i);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.opcode_o !== 16'h0000) begin
            failures++;
            $display("FAIL short_second valid=%b op=%h exp=1/0000", bus.valid_o, bus.opcode_o);
        end
        cyc();
        @(negedge clk_i);
        checks++;
        if (bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL short_empty valid=%b exp=0", bus.valid_o);
        end
        cyc();
        bus.read_i = 1'b0;
    endtask

    task automatic test_long_split();
        bus.write_i = 1'b1;
        bus.data_i  = 32'h0120_DEAD;
        cyc();
        bus.write_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (bus.valid_o !== 1'b0) begin
                failures++;
                $display("FAIL long_partial cycle=%0d valid=%b exp=0", i, bus.valid_o);
            end
            cyc();
        end
        bus.write_i = 1'b1;
        bus.data_i  = 32'hBEEF_0400;
        cyc();
        bus.write_i = 1'b0;
        bus.read_i  = 1'b1;
        @(negedge clk_i);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.opcode_o !== 16'h0120 || bus.operand_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL long_whole valid=%b op=%h operand=%h exp=1/0120/deadbeef",
                     bus.valid_o, bus.opcode_o, bus.operand_o);
        end
        cyc();
        @(negedge clk_i);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.opcode_o !== 16'h0400) begin
            failures++;
            $display("FAIL long_next valid=%b op=%h exp=1/0400", bus.valid_o, bus.opcode_o);
        end
        cyc();
        bus.read_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL long_drained valid=%b exp=0", bus.valid_o);
        end
        cyc();
    endtask

    task automatic test_full();
        int ov0;
        for (int i = 0; i < 4; i++) begin
            bus.write_i = 1'b1;
            bus.data_i  = {16'(16'h8001 + 2 * i), 16'(16'h8002 + 2 * i)};
            cyc();
        end
        bus.write_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.full_o !== 1'b1 || bus.opcode_o !== 16'h8001) begin
            failures++;
            $display("FAIL full_after4 full=%b op=%h exp=1/8001", bus.full_o, bus.opcode_o);
        end
        ov0 = overflow;
        cyc();
        bus.write_i = 1'b1;
        bus.data_i  = 32'hAAAA_BBBB;
        cyc();
        bus.write_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.full_o !== 1'b1 || (overflow - ov0) != 1) begin
            failures++;
            $display("FAIL full_drop full=%b flagged=%0d exp=1/1", bus.full_o, overflow - ov0);
        end
        cyc();
        bus.read_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            checks++;
            if (bus.valid_o !== 1'b1 || bus.opcode_o !== 16'(16'h8001 + i)) begin
                failures++;
                $display("FAIL full_drain idx=%0d valid=%b op=%h exp=1/%h",
                         i, bus.valid_o, bus.opcode_o, 16'(16'h8001 + i));
            end
            cyc();
        end
        bus.read_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.valid_o !== 1'b0 || bus.full_o !== 1'b0) begin
            failures++;
            $display("FAIL full_empty valid=%b full=%b exp=0/0", bus.valid_o, bus.full_o);
        end
        cyc();
    endtask

    task automatic test_wrap();
        bus.write_i = 1'b1;
        bus.data_i  = 32'h8111_8222;
        cyc();
        bus.write_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre valid=%b exp=1", bus.valid_o);
        end
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.full_o !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async valid=%b full=%b exp=0/0", bus.valid_o, bus.full_o);
        end
        cyc();
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.write_i = 1'b1;
            bus.data_i  = {16'(16'h8001 + 2 * i), 16'(16'h8002 + 2 * i)};
            cyc();
        end
        bus.write_i = 1'b0;
        bus.read_i  = 1'b1;
        repeat (6) cyc();
        bus.read_i  = 1'b0;
        bus.write_i = 1'b1;
        bus.data_i  = 32'h0300_1234;
        cyc();
        bus.data_i  = 32'h5678_8ABC;
        @(negedge clk_i);
        checks++;
        if (bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL wrap_partial valid=%b exp=0", bus.valid_o);
        end
        cyc();
        bus.write_i = 1'b0;
        bus.read_i  = 1'b1;
        @(negedge clk_i);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.opcode_o !== 16'h0300 || bus.operand_o !== 32'h12345678) begin
            failures++;
            $display("FAIL wrap_operand valid=%b op=%h operand=%h exp=1/0300/12345678",
                     bus.valid_o, bus.opcode_o, bus.operand_o);
        end
        cyc();
        @(negedge clk_i);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.opcode_o !== 16'h8ABC) begin
            failures++;
            $display("FAIL wrap_next valid=%b op=%h exp=1/8abc", bus.valid_o, bus.opcode_o);
        end
        cyc();
        bus.read_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL wrap_empty valid=%b exp=0", bus.valid_o);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        int p0;
        bus.read_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.write_i = (k % 2 == 0);
            bus.data_i  = {1'b1, 15'($urandom), 1'b1, 15'($urandom)};
            @(negedge clk_i);
            if (k > 0) begin
                checks++;
                if (bus.valid_o !== 1'b1) begin
                    failures++;
                    $display("FAIL throughput cycle=%0d valid=%b exp=1", k, bus.valid_o);
                end
            end
            cyc();
        end
        p0 = pops;
        for (int k = 0; k < 300; k++) begin
            bus.write_i = !bus.full_o && ($urandom_range(0, 3) != 0);
            bus.data_i  = {gen_hw(), gen_hw()};
            bus.read_i  = ($urandom_range(0, 3) != 0);
            cyc();
        end
        bus.write_i = 1'b0;
        bus.read_i  = 1'b1;
        repeat (12) cyc();
        bus.read_i = 1'b0;
        checks++;
        if ((pops - p0) < 50) begin
            failures++;
            $display("FAIL random_pops got=%0d exp>=50", pops - p0);
        end
        rst_i = 1'b0;
        cyc();
        rst_i = 1'b1;
    endtask

`ifdef CPU_IFIFO_FLUSH_EN
    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            bus.write_i = 1'b1;
            bus.data_i  = {16'(16'h8001 + 2 * i), 16'(16'h8002 + 2 * i)};
            cyc();
        end
        bus.data_i = 32'h1111_2222;
        flush_i    = 1'b1;
        cyc();
        bus.write_i = 1'b0;
        flush_i     = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.valid_o !== 1'b0 || bus.full_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear valid=%b full=%b exp=0/0", bus.valid_o, bus.full_o);
        end
        cyc();
        bus.write_i = 1'b1;
        bus.data_i  = 32'h8009_800A;
        cyc();
        bus.write_i = 1'b0;
        bus.read_i  = 1'b1;
        @(negedge clk_i);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.opcode_o !== 16'h8009) begin
            failures++;
            $display("FAIL flush_after valid=%b op=%h exp=1/8009", bus.valid_o, bus.opcode_o);
        end
        repeat (2) cyc();
        bus.read_i = 1'b0;
        cyc();
    endtask
`endif

    initial begin
        bus.write_i = 1'b0;
        bus.data_i  = '0;
        bus.read_i  = 1'b0;
        test_reset();
        test_short_pair();
        test_long_split();
        test_full();
        test_wrap();
        test_back_to_back();
`ifdef CPU_IFIFO_FLUSH_EN
        test_flush();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cpu_insn_fifo.md
# cpu_insn_fifo

Instruction FIFO between the fetch unit and the instruction decoder. Accepts 32-bit big-endian words from fetch, buffers them as 16-bit halfwords and presents whole instructions to decode: a 16-bit opcode plus, for long-form opcodes, the following 32-bit operand. It handles instruction boundaries that do not line up with fetch words, and gives decode a valid/read handshake.

## Interface
- DEPTH, 8: buffer capacity in halfwords; power of two, minimum 4.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- write_i  in  1  fetch presents a word this cycle.
- data_i  in  32  fetch word; [31:16] is the earlier halfword in program order.
- full_o  out  1  fewer than 2 halfword slots free; fetch must hold write_i low.
- opcode_o  out  16  opcode at the head of the buffer.
- operand_o  out  32  operand for long-form opcodes ({head+1, head+2}); don't-care otherwise.
- valid_o  out  1  a complete instruction is present at the head.
- read_i  in  1  decode consumes the head instruction; takes effect only when valid_o=1.
- flush_i  in  1  discard all buffered halfwords (present only with CPU_IFIFO_FLUSH_EN).

## Operation
- Storage: DEPTH x 16 circular buffer, plus head pointer, tail pointer and halfword count (range 0..DEPTH). Pointers wrap modulo DEPTH.
- Write: accepted when write_i=1 and full_o=0.
  - buf[tail] takes data_i[31:16]; buf[tail+1] takes data_i[15:0].
  - tail advances by 2; count increases by 2.
  - A write while full_o=1 is ignored and the word is lost. Fetch must not do this; the bench flags it.
- Length classification is done on opcode_o[15:8]. An opcode is long (48-bit) if that field is one of:
  - 0x01, 0x03, 0x08, 0x09, 0x0C, 0x0D, 0x1A, 0x1B, 0x1D, 0x1F,
  - 0x20, 0x22, 0x24, 0x30, 0x36, 0x37, 0x38, 0x39.
  - Every other opcode is short (16-bit), including every opcode with bit 15 set.
- valid_o:
  - Short head: valid_o = (count ≥ 1).
  - Long head: valid_o = (count ≥ 3).
- Pop: when valid_o=1 and read_i=1, head advances by 1 (short) or 3 (long), and count decreases by the same amount.
- Write and pop in the same cycle: both take effect; new count = count + 2 − popped.
- full_o = (count > DEPTH−2). It is computed from the registered count and does not look ahead to a same-cycle pop.
- A long opcode whose operand halfwords are not yet written holds valid_o=0. The head does not advance until the operand arrives. No partial instruction is ever presented.

## Timing
- Reset (rst_i=0, asynchronous): head=0, tail=0, count=0, so valid_o=0 and full_o=0. Buffer contents are not reset.
- opcode_o, operand_o, valid_o and full_o are combinational from registered state only. There is no combinational path from write_i or data_i to any output.
- Latency: a word written at edge N can produce valid_o=1 in the cycle after edge N.
- Throughput: one instruction per cycle; 2 halfwords per cycle in.
- Wrap-around: operand halfwords straddling index DEPTH−1 → 0 are read correctly.
- Reset asserted mid-operation clears state immediately. The first edge after release behaves as a fresh start.

## Configuration
- CPU_IFIFO_FLUSH_EN defined:
  - flush_i port exists.
  - When flush_i=1 at an edge: head=tail=0 and count=0.
  - flush_i has priority over write and pop in that cycle; a same-cycle write is discarded.
- CPU_IFIFO_FLUSH_EN undefined: no flush_i port and no flush logic. Only reset clears the buffer.

## Test plan
- Reset, then no writes → valid_o=0 and full_o=0 for 10 cycles.
- Write 0x8105_0000, with read_i held at 1:
  - opcode_o=0x8105 with valid_o=1 on the next cycle;
  - then opcode_o=0x0000 with valid_o=1;
  - then valid_o=0.
- Write 0x0120_DEAD, idle 3 cycles, then write 0xBEEF_0400:
  - valid_o=0 while only the first word is buffered;
  - after the second write: opcode_o=0x0120, operand_o=0xDEADBEEF, valid_o=1;
  - after that pop: opcode_o=0x0400.
- DEPTH=8, read_i=0, four writes:
  - full_o=1 after the 4th write;
  - a 5th write is dropped and the buffer contents are unchanged;
  - then drain and check all 8 halfwords in order.
- Wrap-around case: pre-advance head to 6, then write 0x0300_1234 and 0x5678_xxxx so a jsra straddles the wrap → operand_o=0x12345678 is presented intact.
- Flush case (CPU_IFIFO_FLUSH_EN): with 6 halfwords buffered, assert flush_i together with write_i → count=0 and valid_o=0 on the next cycle, and the written word is absent from later output.
